// File: rtl/multi_channel_ni.sv
// Multi-channel network interface: one small FIFO per input channel feeding
// a single registered output stage. An arbiter picks which non-empty channel
// is popped. It uses either strict priority or round-robin order. The popped
// payload is tagged with this node's ID and the channel index.
module multi_channel_ni #(
    parameter logic [4:0] ID       = 5'h0,
    parameter int         NUM_CH   = 2,
    parameter int         DEPTH    = 4,
    parameter int         ARB_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     Wr_i,
    input  logic [NUM_CH*24-1:0]  WrData_i,
    output logic [NUM_CH-1:0]     Full_o,
    output logic [NUM_CH-1:0]     Overflow_o,
    output logic                  Valid_o,
    output logic [31:0]           Data_o,
    input  logic                  Ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(NUM_CH);

    logic [23:0]       mem    [NUM_CH][DEPTH];
    logic [CW-1:0]     count  [NUM_CH];
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] non_empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant;
    logic              any_ready;
    logic              loadable;
    logic              do_pop;
    logic [2:0]        ch_field;
    logic [23:0]       head;
    int                start_idx;
    int                scan_idx;

    // Per-channel status decoded from the registered counts only
    always_comb begin
        full      = '0;
        non_empty = '0;
        push      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]      = (count[c] == CW'(DEPTH));
            non_empty[c] = (count[c] != '0);
            push[c]      = Wr_i[c] && !full[c];
        end
    end

    assign Full_o = full;

    // Arbiter: scan channels starting at the priority origin and grant the first non-empty one
    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        scan_idx  = 0;
        start_idx = 0;
        if (ARB_MODE == 1) begin
            start_idx = int'(last_grant) + 1;
            if (start_idx >= NUM_CH) begin
                start_idx = 0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = start_idx + i;
            if (scan_idx >= NUM_CH) begin
                scan_idx = scan_idx - NUM_CH;
            end
            if (!any_ready && non_empty[scan_idx]) begin
                grant     = scan_idx[GW-1:0];
                any_ready = 1'b1;
            end
        end
    end

    // Pop decision: the output register takes a new word only when empty or being drained
    always_comb begin
        loadable = !Valid_o || Ready_i;
        do_pop   = loadable && any_ready;
        pop      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = do_pop && (grant == GW'(c));
        end
        ch_field          = '0;
        ch_field[GW-1:0]  = grant;
        head              = mem[grant][rd_ptr[grant]];
    end

    // FIFO storage is not reset; validity is tracked by the counts
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= WrData_i[24*c +: 24];
            end
        end
    end

    // Pointer, count and sticky overflow bookkeeping for every channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count[c]  <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            Overflow_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + CW'(1);
                    2'b01:   count[c] <= count[c] - CW'(1);
                    default: count[c] <= count[c];
                endcase
                if (Wr_i[c] && full[c]) begin
                    Overflow_o[c] <= 1'b1;
                end
            end
        end
    end

    // Output register: load the granted head, hold while stalled, go idle when nothing is queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_o    <= 1'b0;
            Data_o     <= 32'h0;
            last_grant <= GW'(NUM_CH - 1);
        end else if (loadable) begin
            if (any_ready) begin
                Valid_o    <= 1'b1;
                Data_o     <= {ID, ch_field, head};
                last_grant <= grant;
            end else begin
                Valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_ni.sv
// Directed bench for multi_channel_ni: two instances (strict priority and
// round-robin) share the same stimulus, ID=3, three channels, depth four.
module tb_multi_channel_ni;

    logic        clk;
    logic        rst;
    logic [2:0]  wr;
    logic [71:0] wr_data;
    logic        ready;

    logic [2:0]  full_sp, ovf_sp, full_rr, ovf_rr;
    logic        valid_sp, valid_rr;
    logic [31:0] data_sp, data_rr;

    int checks;
    int errors;

    logic [31:0] exp_sp [6];
    logic [31:0] exp_rr [6];
    logic [31:0] exp_bp [4];
    int          bp_idx;
    logic        bp_valid;

    multi_channel_ni #(.ID(5'h3), .NUM_CH(3), .DEPTH(4), .ARB_MODE(0)) dut_sp (
        .clk(clk), .rst(rst), .Wr_i(wr), .WrData_i(wr_data),
        .Full_o(full_sp), .Overflow_o(ovf_sp), .Valid_o(valid_sp),
        .Data_o(data_sp), .Ready_i(ready)
    );

    multi_channel_ni #(.ID(5'h3), .NUM_CH(3), .DEPTH(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .Wr_i(wr), .WrData_i(wr_data),
        .Full_o(full_rr), .Overflow_o(ovf_rr), .Valid_o(valid_rr),
        .Data_o(data_rr), .Ready_i(ready)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge
    task automatic applyStimulus(input logic [2:0] w, input logic [23:0] d0, input logic [23:0] d1,
                                 input logic [23:0] d2, input logic rdy);
        wr      = w;
        wr_data = {d2, d1, d0};
        ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        wr      = '0;
        wr_data = '0;
        ready   = 1'b0;

        exp_sp = '{32'h18A00000, 32'h18B00000, 32'h19A00001, 32'h19B00001, 32'h1AA00002, 32'h1AB00002};
        exp_rr = '{32'h18A00000, 32'h19A00001, 32'h1AA00002, 32'h18B00000, 32'h19B00001, 32'h1AB00002};
        exp_bp = '{32'h1AC00000, 32'h1AC00001, 32'h1AC00002, 32'h1AC00003};

        // Reset state
        #12;
        checkOutput("rst_valid", 32'(valid_sp), 32'h0);
        checkOutput("rst_data", data_sp, 32'h0);
        checkOutput("rst_full", 32'(full_sp), 32'h0);
        checkOutput("rst_ovf", 32'(ovf_sp), 32'h0);
        checkOutput("rst_valid_rr", 32'(valid_rr), 32'h0);
        rst = 1'b0;

        // Single word through channel 1, no bypass
        applyStimulus(3'b010, 24'h0, 24'hABCDEF, 24'h0, 1'b1);
        checkOutput("single_no_bypass", 32'(valid_sp), 32'h0);
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        checkOutput("single_valid", 32'(valid_sp), 32'h1);
        checkOutput("single_data", data_sp, 32'h19ABCDEF);
        checkOutput("single_data_rr", data_rr, 32'h19ABCDEF);
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        checkOutput("single_idle", 32'(valid_sp), 32'h0);

        // Full / overflow: park a channel-1 word in the stalled output, then fill channel 0
        applyStimulus(3'b010, 24'h0, 24'h111111, 24'h0, 1'b0);
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b0);
        checkOutput("stall_data", data_sp, 32'h19111111);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(3'b001, 24'(i), 24'h0, 24'h0, 1'b0);
            if (i == 3) checkOutput("full_after3", 32'(full_sp), 32'h0);
            if (i == 4) begin
                checkOutput("full_after4", 32'(full_sp), 32'h1);
                checkOutput("ovf_after4", 32'(ovf_sp), 32'h0);
            end
        end
        checkOutput("ovf_after5", 32'(ovf_sp), 32'h1);
        checkOutput("ovf_after5_rr", 32'(ovf_rr), 32'h1);
        checkOutput("full_after5", 32'(full_sp), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
            checkOutput("drain_data", data_sp, {8'h18, 24'(i)});
            checkOutput("drain_data_rr", data_rr, {8'h18, 24'(i)});
            if (i == 1) checkOutput("drain_not_full", 32'(full_sp), 32'h0);
        end
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        checkOutput("drain_idle", 32'(valid_sp), 32'h0);
        checkOutput("ovf_sticky", 32'(ovf_sp), 32'h1);

        // Reset pulse clears sticky overflow and restores round-robin origin
        rst = 1'b1;
        #1;
        checkOutput("rst2_ovf", 32'(ovf_sp), 32'h0);
        rst = 1'b0;

        // Preload two words per channel with the output stalled
        applyStimulus(3'b111, 24'hA00000, 24'hA00001, 24'hA00002, 1'b0);
        applyStimulus(3'b111, 24'hB00000, 24'hB00001, 24'hB00002, 1'b0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("prio_order", data_sp, exp_sp[k]);
            checkOutput("rr_order", data_rr, exp_rr[k]);
            applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        end
        checkOutput("order_idle", 32'(valid_sp), 32'h0);
        checkOutput("order_idle_rr", 32'(valid_rr), 32'h0);

        // Backpressure: Ready toggles every cycle on a four-word stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b100, 24'h0, 24'h0, 24'hC00000 + 24'(i), 1'b0);
        end
        bp_idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bp_valid = valid_sp;
            if (bp_valid) begin
                if (bp_idx < 4) checkOutput("bp_data", data_sp, exp_bp[bp_idx]);
                else            checkOutput("bp_extra", 32'(bp_valid), 32'h0);
            end
            applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, (cyc % 2) == 0);
            if (bp_valid && (cyc % 2) == 0) begin
                bp_idx++;
            end else if (bp_valid && bp_idx < 4) begin
                checkOutput("bp_hold", data_sp, exp_bp[bp_idx]);
            end
        end
        checkOutput("bp_count", 32'(bp_idx), 32'd4);
        checkOutput("bp_idle_rr", 32'(valid_rr), 32'h0);

        // Reset mid-stream with words queued, output valid, channel 0 overflowed
        applyStimulus(3'b010, 24'h0, 24'hD00001, 24'h0, 1'b0);
        applyStimulus(3'b011, 24'hE00001, 24'hD00002, 24'h0, 1'b0);
        applyStimulus(3'b011, 24'hE00002, 24'hD00003, 24'h0, 1'b0);
        applyStimulus(3'b011, 24'hE00003, 24'hD00004, 24'h0, 1'b0);
        applyStimulus(3'b001, 24'hE00004, 24'h0, 24'h0, 1'b0);
        applyStimulus(3'b001, 24'hE00005, 24'h0, 24'h0, 1'b0);
        checkOutput("pre_rst_valid", 32'(valid_sp), 32'h1);
        checkOutput("pre_rst_data", data_sp, 32'h19D00001);
        checkOutput("pre_rst_full", 32'(full_sp), 32'h1);
        checkOutput("pre_rst_ovf", 32'(ovf_sp), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(valid_sp), 32'h0);
        checkOutput("mid_rst_data", data_sp, 32'h0);
        checkOutput("mid_rst_full", 32'(full_sp), 32'h0);
        checkOutput("mid_rst_ovf", 32'(ovf_sp), 32'h0);
        checkOutput("mid_rst_valid_rr", 32'(valid_rr), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
            checkOutput("post_rst_quiet", 32'(valid_sp), 32'h0);
            checkOutput("post_rst_quiet_rr", 32'(valid_rr), 32'h0);
        end

        // Writes are accepted on the first edge after reset release
        rst = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(3'b100, 24'h0, 24'h0, 24'h123456, 1'b1);
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        checkOutput("first_edge_valid", 32'(valid_sp), 32'h1);
        checkOutput("first_edge_data", data_sp, 32'h1A123456);
        applyStimulus(3'b000, 24'h0, 24'h0, 24'h0, 1'b1);
        checkOutput("first_edge_idle", 32'(valid_sp), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_ni.md
MULTI_CHANNEL_NI -- requirements
Module: multi_channel_ni

Interface
REQ-001 SHALL have parameter ID, default 5'h0: 5-bit node ID placed in every output word.
REQ-002 SHALL have parameter NUM_CH, default 2: number of input channels, legal range 2..8.
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO depth, a power of 2 in the range 2..16.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = strict priority (ch0 highest), 1 = round-robin.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 Wr_i  input  NUM_CH  per-channel write request, bit c for channel c.
REQ-008 WrData_i  input  NUM_CH*24  channel c payload on bits [24c+23:24c].
REQ-009 Full_o  output  NUM_CH  bit c high when FIFO c holds DEPTH words.
REQ-010 Overflow_o  output  NUM_CH  sticky flag: bit c set on a write to FIFO c while it is full.
REQ-011 Valid_o  output  1  Data_o holds a valid word.
REQ-012 Data_o  output  32  {ID[4:0], ch[2:0], payload[23:0]}.
REQ-013 Ready_i  input  1  downstream accepts the word when Valid_o && Ready_i.

Function
REQ-014 Each channel SHALL have an independent FIFO of DEPTH x 24 bits with a count register of clog2(DEPTH)+1 bits.
REQ-015 Push rule: a write SHALL occur on channel c when Wr_i[c] && !Full_o[c]; Full_o SHALL be decoded from the registered count only.
REQ-016 Wr_i[c] while Full_o[c]: data SHALL be dropped, count and memory unchanged, Overflow_o[c] set until reset.
REQ-017 Output stage: a single register SHALL hold Valid_o/Data_o; it SHALL be loadable when !Valid_o || Ready_i.
REQ-018 Load: when loadable and at least one FIFO is non-empty, the granted channel's head SHALL be popped and registered in the same edge, with Valid_o=1.
REQ-019 When loadable and all FIFOs are empty, Valid_o SHALL go to 0.
REQ-020 While Valid_o && !Ready_i, Data_o SHALL be held stable and no FIFO SHALL pop.
REQ-021 Arbitration in ARB_MODE=0 SHALL grant the lowest-index non-empty channel.
REQ-022 Arbitration in ARB_MODE=1 SHALL grant the first non-empty channel searching upward from (last_grant+1) mod NUM_CH.
REQ-023 last_grant SHALL update only on an actual pop.
REQ-024 Latency: a word written at edge k SHALL appear on Data_o no earlier than edge k+1 (no bypass), given the channel is granted and the output stage is loadable.
REQ-025 Throughput: with Ready_i held at 1 and data available, SHALL sustain one word per cycle.
REQ-026 Same-channel push and pop in one edge SHALL leave count unchanged and preserve FIFO order.
REQ-027 Pop from a full FIFO with Wr_i high SHALL not push, because Full_o was 1 at that edge; count SHALL become DEPTH-1.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The ch field SHALL be the granted index, zero-extended to 3 bits.

Reset
REQ-030 rst=1 SHALL asynchronously clear:
  - all counts and pointers;
  - Overflow_o;
  - Valid_o=0 and Data_o=32'h0;
  - last_grant=NUM_CH-1 (ch0 first in RR).
REQ-031 Full_o SHALL be 0 during and after reset; a word in flight mid-operation SHALL be discarded.
REQ-032 After rst deasserts, the block SHALL accept writes on the first rising edge.

Verification (ID=5'h3, NUM_CH=3, DEPTH=4)
REQ-033 Single word: ch1 writes 24'hABCDEF, Ready_i=1 -> Valid_o high one edge later with Data_o=32'h19ABCDEF, then Valid_o=0.
REQ-034 Full/overflow: five writes to ch0 with Ready_i=0 -> Full_o[0]=1 after the fourth write, fifth dropped, Overflow_o[0]=1; drain returns words 1-4 in order.
REQ-035 Priority: ARB_MODE=0, ch0..ch2 each hold 2 words, Ready_i=1 -> output channel order 0,0,1,1,2,2 on consecutive cycles.
REQ-036 Round-robin: ARB_MODE=1, same preload -> order 0,1,2,0,1,2.
REQ-037 Backpressure: Ready_i toggling 1/0 each cycle -> no word duplicated or lost, Data_o stable while stalled.
REQ-038 Reset mid-stream: rst pulsed with 3 words queued and Valid_o=1 -> Valid_o=0, Full_o=0, Overflow_o=0 immediately; no old data ever emitted afterwards.
